logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the two-input AND/OR/NOT gate block.
- WIDTH-bit bitwise logic unit with 8 selectable operations and a 2-stage valid/ready pipeline.
- Has an accumulate mode that folds successive operands into an internal register.
- Sits between operand sources (switch/register front end) and display/consumer logic in the lab datapath.

---
 rtl/logic_unit_pkg.sv | 29 ++
 rtl/logic_op_comb.sv | 28 ++
 rtl/logic_unit_pipe.sv | 114 +++++++++++
 tb/tb_logic_unit_pipe.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Opcode encoding and op enum shared by the logic unit pipeline.
// Optional reduction outputs are enabled with LOGIC_UNIT_REDUCE_EN.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic [2:0] {
        OpAnd  = OP_AND,
        OpOr   = OP_OR,
        OpNot  = OP_NOT,
        OpXor  = OP_XOR,
        OpNand = OP_NAND,
        OpNor  = OP_NOR,
        OpXnor = OP_XNOR,
        OpPass = OP_PASS
    } opE;

    function automatic opE toOp(input logic [2:0] v);
        return opE'(v);
    endfunction

endpackage

// File: rtl/logic_op_comb.sv
// Combinational WIDTH-bit bitwise op evaluator.
// Used once in the second pipeline stage of logic_unit_pipe.
module logic_op_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (toOp(op))
            OpAnd:  y = a & b;
            OpOr:   y = a | b;
            OpNot:  y = ~a;
            OpXor:  y = a ^ b;
            OpNand: y = ~(a & b);
            OpNor:  y = ~(a | b);
            OpXnor: y = ~(a ^ b);
            OpPass: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with accumulator.
// Define LOGIC_UNIT_REDUCE_EN to add registered reduction outputs.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [OPW-1:0]   iOp,
    input  logic             iAcc,
    input  logic             iLoad,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oZero,
    output logic [WIDTH-1:0] oAccum
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    output logic             oRedAnd,
    output logic             oRedOr,
    output logic             oRedXor
`endif
);

    logic             s1Valid;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic [OPW-1:0]   s1Op;
    logic             s1Acc;
    logic             s1Load;

    logic [WIDTH-1:0] accReg;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] opRes;
    logic [WIDTH-1:0] res;
    logic             s2Adv;

    assign s2Adv  = !oValid | iReady;
    assign oReady = !s1Valid | s2Adv;
    assign oAccum = accReg;

    // acc is read here on the same edge that writes it, so chained
    // accumulates need no bubble.
    assign opB = s1Acc ? accReg : s1B;
    assign res = s1Load ? s1A : opRes;

    logic_op_comb #(
        .WIDTH(WIDTH)
    ) uOp (
        .a (s1A),
        .b (opB),
        .op(s1Op),
        .y (opRes)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1Valid <= 1'b0;
            s1A     <= '0;
            s1B     <= '0;
            s1Op    <= '0;
            s1Acc   <= 1'b0;
            s1Load  <= 1'b0;
        end else if (oReady) begin
            s1Valid <= iValid;
            if (iValid) begin
                s1A    <= iA;
                s1B    <= iB;
                s1Op   <= iOp;
                s1Acc  <= iAcc;
                s1Load <= iLoad;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oValid  <= 1'b0;
            oResult <= '0;
            oZero   <= 1'b1;
            accReg  <= '0;
        end else if (s2Adv) begin
            oValid <= s1Valid;
            if (s1Valid) begin
                oResult <= res;
                oZero   <= ~|res;
                if (s1Load | s1Acc) begin
                    accReg <= res;
                end
            end
        end
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oRedAnd <= 1'b0;
            oRedOr  <= 1'b0;
            oRedXor <= 1'b0;
        end else if (s2Adv && s1Valid) begin
            oRedAnd <= &res;
            oRedOr  <= |res;
            oRedXor <= ^res;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized self-checking bench for logic_unit_pipe (WIDTH=8).
// Covers LOGIC_UNIT_REDUCE_EN outputs when that macro is defined.
module tb_logic_unit_pipe;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady;
    logic [7:0] iA = '0;
    logic [7:0] iB = '0;
    logic [2:0] iOp = '0;
    logic       iAcc = 1'b0;
    logic       iLoad = 1'b0;
    logic       oValid;
    logic       iReady = 1'b0;
    logic [7:0] oResult;
    logic       oZero;
    logic [7:0] oAccum;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic       oRedAnd;
    logic       oRedOr;
    logic       oRedXor;
`endif

    logic_unit_pipe #(
        .WIDTH(8),
        .OPW  (3)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iValid (iValid),
        .oReady (oReady),
        .iA     (iA),
        .iB     (iB),
        .iOp    (iOp),
        .iAcc   (iAcc),
        .iLoad  (iLoad),
        .oValid (oValid),
        .iReady (iReady),
        .oResult(oResult),
        .oZero  (oZero),
        .oAccum (oAccum)
`ifdef LOGIC_UNIT_REDUCE_EN
        ,
        .oRedAnd(oRedAnd),
        .oRedOr (oRedOr),
        .oRedXor(oRedXor)
`endif
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [7:0] res;
        logic [7:0] acc;
    } expT;

    expT        q[$];
    logic [7:0] litQ[$];
    logic [7:0] mAcc = '0;
    logic [7:0] lastAcc = '0;
    int         nChecks = 0;
    int         nFail = 0;

    function automatic logic [7:0] refOp(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model: results are computed in acceptance order and
    // retired in the same order.
    always @(negedge iClk) begin
        expT        e;
        logic [7:0] l;
        logic [7:0] r;
        if (!iRst_n) begin
            q.delete();
            litQ.delete();
            mAcc    = '0;
            lastAcc = '0;
            chk("rst_valid", oValid, 0);
            chk("rst_result", oResult, 0);
            chk("rst_zero", oZero, 1);
            chk("rst_accum", oAccum, 0);
`ifdef LOGIC_UNIT_REDUCE_EN
            chk("rst_red", {oRedAnd, oRedOr, oRedXor}, 0);
`endif
        end else begin
            if (q.size() == 0) chk("valid_empty", oValid, 0);
            else if (q.size() >= 2) chk("valid_full", oValid, 1);
            if (oValid && q.size() > 0) begin
                e = q[0];
                chk("result", oResult, e.res);
                chk("zero", oZero, (e.res == 8'h00));
                chk("accum", oAccum, e.acc);
`ifdef LOGIC_UNIT_REDUCE_EN
                chk("red_and", oRedAnd, (e.res == 8'hFF));
                chk("red_or", oRedOr, (e.res != 8'h00));
                chk("red_xor", oRedXor, ($countones(e.res) % 2));
`endif
            end else if (!oValid) begin
                chk("accum_idle", oAccum, lastAcc);
            end
            if (oValid && iReady && q.size() > 0) begin
                if (litQ.size() > 0) begin
                    l = litQ.pop_front();
                    chk("lit_result", oResult, l);
                end
                lastAcc = q[0].acc;
                void'(q.pop_front());
            end
            if (iValid && oReady) begin
                if (iLoad) begin
                    r    = iA;
                    mAcc = iA;
                end else if (iAcc) begin
                    r    = refOp(iOp, iA, mAcc);
                    mAcc = r;
                end else begin
                    r = refOp(iOp, iA, iB);
                end
                e.res = r;
                e.acc = mAcc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic acc,
                        input logic load);
        int n;
        iA     = a;
        iB     = b;
        iOp    = op;
        iAcc   = acc;
        iLoad  = load;
        iValid = 1'b1;
        n      = 0;
        @(negedge iClk);
        while (!oReady && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 100) chk("send_timeout", oReady, 1);
        @(posedge iClk);
        #1;
        iValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || litQ.size() != 0) && n < 200) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 200) chk("drain", q.size(), 0);
    endtask

    logic [7:0] opExp[8];
    bit         pending;

    initial begin
        opExp = '{8'h81, 8'hE7, 8'h3C, 8'h66, 8'h7E, 8'h18, 8'h99, 8'hC3};
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        #1;
        chk("ready_after_rst", oReady, 1);
        iReady = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge iClk);
            #1;
            send(8'hC3, 8'hA5, i[2:0], 1'b0, 1'b0);
            @(negedge iClk);
            chk("lat_not_yet", oValid, 0);
            @(negedge iClk);
            chk("lat_valid", oValid, 1);
            chk("op_result", oResult, opExp[i]);
`ifdef LOGIC_UNIT_REDUCE_EN
            if (i == 0) begin
                chk("red81", {oRedAnd, oRedOr, oRedXor}, 3'b010);
            end
`endif
        end
        drain();

        @(posedge iClk);
        #1;
        litQ.push_back(8'hF0);
        litQ.push_back(8'hFF);
        litQ.push_back(8'h3C);
        send(8'hF0, 8'h00, 3'd0, 1'b0, 1'b1);
        send(8'h0F, 8'h00, 3'd3, 1'b1, 1'b0);
        send(8'h3C, 8'h00, 3'd0, 1'b1, 1'b0);
        repeat (3) @(negedge iClk);
        chk("acc_3c", oAccum, 8'h3C);
        @(posedge iClk);
        #1;
        litQ.push_back(8'h00);
        send(8'hC3, 8'h00, 3'd0, 1'b1, 1'b0);
        @(negedge iClk);
        @(negedge iClk);
        chk("acc_zero_flag", oZero, 1);
        drain();

        @(posedge iClk);
        #1;
        litQ.push_back(8'h5A);
        send(8'h5A, 8'hFF, 3'd0, 1'b1, 1'b1);
        repeat (3) @(negedge iClk);
        chk("load_wins", oAccum, 8'h5A);
        drain();

        @(posedge iClk);
        #1;
        iReady = 1'b0;
        for (int i = 0; i < 4; i++) litQ.push_back(opExp[i]);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(8'hC3, 8'hA5, i[2:0], 1'b0, 1'b0);
                end
            end
            begin
                repeat (6) @(negedge iClk);
                chk("bp_ready_low", oReady, 0);
                chk("bp_valid", oValid, 1);
                chk("bp_hold", oResult, 8'h81);
                @(posedge iClk);
                #1;
                iReady = 1'b1;
            end
        join
        drain();

`ifdef LOGIC_UNIT_REDUCE_EN
        @(posedge iClk);
        #1;
        send(8'hFF, 8'h00, 3'd7, 1'b0, 1'b0);
        @(negedge iClk);
        @(negedge iClk);
        chk("redFF", {oRedAnd, oRedOr, oRedXor}, 3'b110);
        drain();
`endif

        pending = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge iClk);
            #1;
            if (c == 1000) begin
                iRst_n = 1'b0;
                #1;
                chk("async_valid", oValid, 0);
                chk("async_result", oResult, 0);
                chk("async_zero", oZero, 1);
                chk("async_accum", oAccum, 0);
                iValid  = 1'b0;
                pending = 1'b0;
                @(posedge iClk);
                #1;
                iRst_n = 1'b1;
            end else begin
                if (!pending) begin
                    iA     = 8'($urandom_range(255));
                    iB     = 8'($urandom_range(255));
                    iOp    = 3'($urandom_range(7));
                    iAcc   = ($urandom_range(2) == 0);
                    iLoad  = ($urandom_range(5) == 0);
                    iValid = ($urandom_range(3) != 0);
                end
                iReady = ($urandom_range(3) != 0);
                @(negedge iClk);
                pending = iValid && !oReady;
            end
        end
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        iReady = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFail);
        $finish;
    end

endmodule
